// File: rtl/tracking_pkg.sv
// Shared types for the tracking frame sequencer: FSM states, pixel/coordinate types
// and the tracker result record.
package tracking_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STREAM    = 3'd1,
    WAIT_RES  = 3'd2,
    FRAME_END = 3'd3,
    DONE      = 3'd4
  } state_t;

  typedef logic [23:0] pixel_t;
  typedef logic [11:0] coord_t;

  typedef struct packed {
    coord_t center_x;
    coord_t center_y;
    coord_t width;
    coord_t height;
  } result_t;

endpackage

// File: rtl/tracking_frame_sequencer_if.sv
// Source FIFO, tracker FIFO/result and latched-result signals of the frame sequencer.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface tracking_frame_sequencer_if #(
  parameter int FRAME_W = 8
);
  import tracking_pkg::*;

  logic               src_empty;
  pixel_t             src_dout;
  logic               src_rd_en;
  logic               trk_full;
  logic               trk_wr_en;
  pixel_t             trk_din;
  logic               trk_valid;
  coord_t             trk_center_x;
  coord_t             trk_center_y;
  coord_t             trk_width;
  coord_t             trk_height;
  logic               res_valid;
  coord_t             res_center_x;
  coord_t             res_center_y;
  coord_t             res_width;
  coord_t             res_height;
  logic [FRAME_W-1:0] res_frame;
  logic               res_timeout;

  modport master (
    input  src_empty, src_dout, trk_full,
    input  trk_valid, trk_center_x, trk_center_y, trk_width, trk_height,
    output src_rd_en, trk_wr_en, trk_din,
    output res_valid, res_center_x, res_center_y, res_width, res_height,
    output res_frame, res_timeout
  );

  modport slave (
    output src_empty, src_dout, trk_full,
    output trk_valid, trk_center_x, trk_center_y, trk_width, trk_height,
    input  src_rd_en, trk_wr_en, trk_din,
    input  res_valid, res_center_x, res_center_y, res_width, res_height,
    input  res_frame, res_timeout
  );

endinterface

// File: rtl/raster_counter.sv
// Raster position counter: x runs 0..WIDTH-1, then wraps and bumps y (0..HEIGHT-1).
// last flags the advance that completes the final pixel of the frame.
module raster_counter
  import tracking_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic   clock_50,
  input  logic   reset,
  input  logic   clear,
  input  logic   advance,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  coord_t x_q, x_d, y_q, y_d;
  logic   x_end, y_end;

  always_comb begin
    x_end = (x_q == coord_t'(WIDTH - 1));
    y_end = (y_q == coord_t'(HEIGHT - 1));
    last  = advance && x_end && y_end;
    x_d   = x_q;
    y_d   = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/tracking_frame_sequencer.sv
// Feeds the tracker one raster frame at a time, then waits for its result or a timeout.
//   state     | meaning
//   IDLE      | waiting for start
//   STREAM    | moving pixels source FIFO -> tracker FIFO
//   WAIT_RES  | frame sent; waiting for tracker result or timeout
//   FRAME_END | one cycle: bump frame count, pick next frame or finish
//   DONE      | programmed number of frames completed
module tracking_frame_sequencer
  import tracking_pkg::*;
#(
  parameter int WIDTH   = 720,
  parameter int HEIGHT  = 540,
  parameter int TIMEOUT = 4096,
  parameter int FRAME_W = 8
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] num_frames,
  tracking_frame_sequencer_if.master bus,
  output coord_t             pix_x,
  output coord_t             pix_y,
  output logic [FRAME_W-1:0] frame_count,
  output logic               busy,
  output logic               done
);

  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               launch, xfer, last, capture, expire, wait_tc;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d, frame_inc;
  logic [FRAME_W-1:0] num_frames_q, num_frames_d;
  logic [TW-1:0]      wait_q, wait_d;
  result_t            res_q, res_d;
  logic [FRAME_W-1:0] res_frame_q, res_frame_d;
  logic               res_timeout_q, res_timeout_d;
  logic               res_valid_q, res_valid_d;

  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
    .clock_50 (clock_50),
    .reset    (reset),
    .clear    (launch),
    .advance  (xfer),
    .x        (pix_x),
    .y        (pix_y),
    .last     (last)
  );

  assign frame_inc = frame_count_q + FRAME_W'(1);

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) state_d = STREAM;
        STREAM:     if (xfer && last) state_d = WAIT_RES;
        WAIT_RES:   if (bus.trk_valid || wait_tc) state_d = FRAME_END;
        FRAME_END:  state_d = (num_frames_q != '0 && frame_inc == num_frames_q) ? DONE : STREAM;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Abort suppresses transfers and result capture in the cycle it is seen.
  always_comb begin
    busy          = (state_q != IDLE) && (state_q != DONE);
    done          = (state_q == DONE);
    launch        = start && !abort && (state_q == IDLE || state_q == DONE);
    xfer          = (state_q == STREAM) && !bus.src_empty && !bus.trk_full && !abort;
    capture       = bus.trk_valid && !abort && (state_q == STREAM || state_q == WAIT_RES);
    wait_tc       = (wait_q == '0);
    expire        = (state_q == WAIT_RES) && wait_tc && !abort;
    bus.src_rd_en = xfer;
    bus.trk_wr_en = xfer;
    bus.trk_din   = xfer ? bus.src_dout : '0;
  end

  always_comb begin
    frame_count_d = frame_count_q;
    num_frames_d  = num_frames_q;
    wait_d        = wait_q;
    res_d         = res_q;
    res_frame_d   = res_frame_q;
    res_timeout_d = res_timeout_q;
    res_valid_d   = 1'b0;
    if (launch) begin
      frame_count_d = '0;
      num_frames_d  = num_frames;
      res_timeout_d = 1'b0;
    end else if (state_q == FRAME_END && !abort) begin
      frame_count_d = frame_inc;
    end
    // Wait timer is a down-counter loaded on the last pixel; zero is terminal count.
    if (xfer && last)                       wait_d = WAIT_LOAD;
    else if (state_q == WAIT_RES && !wait_tc) wait_d = wait_q - TW'(1);
    if (capture) begin
      res_d         = '{center_x: bus.trk_center_x, center_y: bus.trk_center_y,
                        width: bus.trk_width, height: bus.trk_height};
      res_frame_d   = frame_count_q;
      res_timeout_d = 1'b0;
      res_valid_d   = 1'b1;
    end else if (expire) begin
      res_d         = '0;
      res_frame_d   = frame_count_q;
      res_timeout_d = 1'b1;
      res_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
      num_frames_q  <= '0;
      wait_q        <= '0;
      res_q         <= '0;
      res_frame_q   <= '0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      num_frames_q  <= num_frames_d;
      wait_q        <= wait_d;
      res_q         <= res_d;
      res_frame_q   <= res_frame_d;
      res_timeout_q <= res_timeout_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign frame_count      = frame_count_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_center_x = res_q.center_x;
  assign bus.res_center_y = res_q.center_y;
  assign bus.res_width    = res_q.width;
  assign bus.res_height   = res_q.height;
  assign bus.res_frame    = res_frame_q;
  assign bus.res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_tracking_frame_sequencer.sv
// Directed/randomized bench for tracking_frame_sequencer on an 8x4 raster, 16-cycle timeout.
module tb_tracking_frame_sequencer;
  import tracking_pkg::*;

  localparam int W = 8, H = 4, TO = 16, FW = 8, NPIX = W * H;

  logic          clock_50 = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] num_frames = '0;
  coord_t        pix_x, pix_y;
  logic [FW-1:0] frame_count;
  logic          busy, done;

  tracking_frame_sequencer_if #(.FRAME_W(FW)) bus ();

  tracking_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO), .FRAME_W(FW)) dut (
    .clock_50    (clock_50),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_frames  (num_frames),
    .bus         (bus),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_count (frame_count),
    .busy        (busy),
    .done        (done)
  );

  always #10 clock_50 = ~clock_50;

  int            errors = 0, checks = 0, cyc = 0;
  pixel_t        pix_mem [512];
  int            sp = 0, push_cnt = 0, tot = 0, frame_base = 0;
  int            last_push_cyc = -1, rv_cyc = -1;
  logic [FW-1:0] nf = '0, fc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive source/tracker-full at the negedge, sample and score 1 ns later.
  task automatic tick(input bit e = 1'b0, input bit f = 1'b0);
    bus.src_empty = e;
    bus.trk_full  = f;
    bus.src_dout  = pix_mem[sp];
    #1;
    chk("rd_eq_wr", bus.src_rd_en, bus.trk_wr_en);
    chk("pix_x", pix_x, coord_t'(tot % W));
    chk("pix_y", pix_y, coord_t'((tot / W) % H));
    if (bus.src_rd_en) chk("pop_blocked", {e, f, abort}, 3'b000);
    if (bus.trk_wr_en) begin
      chk("din_order", bus.trk_din, pix_mem[push_cnt]);
      push_cnt++;
      tot++;
      last_push_cyc = cyc;
    end
    if (bus.src_rd_en) sp++;
    if (bus.res_valid) rv_cyc = cyc;
    cyc++;
    @(negedge clock_50);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, frame_count, pix_x, pix_y, bus.res_valid,
                        bus.res_timeout, bus.res_frame}, '0);
    chk({tag, "_res"}, {bus.res_center_x, bus.res_center_y, bus.res_width, bus.res_height}, '0);
    chk({tag, "_xfer"}, {bus.src_rd_en, bus.trk_wr_en, bus.trk_din}, '0);
  endtask

  task automatic do_start(input logic [FW-1:0] n);
    num_frames = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    nf         = n;
    fc         = '0;
    tot        = 0;
    frame_base = push_cnt;
  endtask

  // pattern 0: free flow; 1: trk_full every other cycle, src_empty cycles 3-7; 2: random
  task automatic stream_frame(input int pattern, input int upto);
    for (int i = 0; i < 400 && push_cnt - frame_base < upto; i++) begin
      case (pattern)
        1:       tick(i >= 3 && i <= 7, i[0]);
        2:       tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        default: tick();
      endcase
    end
  endtask

  // Wait for the frame's result; tv_delay < 0 means the tracker stays silent (timeout).
  task automatic frame_result(input string tag, input int tv_delay,
                              input coord_t cx, input coord_t cy, input coord_t w, input coord_t h);
    int c, base;
    bit to, fin;
    c      = last_push_cyc;
    base   = push_cnt;
    rv_cyc = -1;
    to     = (tv_delay < 0);
    for (int i = 0; i < 3 * TO && rv_cyc < 0; i++) begin
      if (cyc == c + tv_delay) begin
        bus.trk_valid    = 1'b1;
        bus.trk_center_x = cx;
        bus.trk_center_y = cy;
        bus.trk_width    = w;
        bus.trk_height   = h;
      end
      tick();
      bus.trk_valid = 1'b0;
    end
    chk({tag, "_latency"}, rv_cyc - c, to ? TO + 1 : tv_delay + 1);
    chk({tag, "_timeout"}, bus.res_timeout, to);
    chk({tag, "_geom"}, {bus.res_center_x, bus.res_center_y, bus.res_width, bus.res_height},
        to ? 48'd0 : {cx, cy, w, h});
    chk({tag, "_res_frame"}, bus.res_frame, fc);
    chk({tag, "_no_push_wait"}, push_cnt, base);
    fc  = fc + 1'b1;
    fin = (nf != 0) && (fc == nf);
    chk({tag, "_frame_count"}, frame_count, fc);
    chk({tag, "_done"}, done, fin);
    chk({tag, "_busy"}, busy, !fin);
    frame_base = push_cnt;
  endtask

  initial begin
    coord_t rx, ry, rw, rh;
    int     t, pre;
    foreach (pix_mem[i]) pix_mem[i] = pixel_t'($urandom);
    bus.src_empty = 1'b0; bus.src_dout = '0; bus.trk_full = 1'b0; bus.trk_valid = 1'b0;
    bus.trk_center_x = '0; bus.trk_center_y = '0; bus.trk_width = '0; bus.trk_height = '0;
    #5;
    chk_zero("reset");
    @(negedge clock_50);
    reset = 1'b1;

    // single frame, tracker answers 5 cycles after the last push
    do_start(8'd1);
    stream_frame(0, NPIX);
    chk("s1_pushes", push_cnt - frame_base, NPIX);
    frame_result("s1", 5, 12'd3, 12'd2, 12'd4, 12'd2);

    // backpressure from both FIFOs
    do_start(8'd1);
    stream_frame(1, NPIX);
    chk("s2_pushes", push_cnt - frame_base, NPIX);
    frame_result("s2", 3, coord_t'($urandom), coord_t'($urandom), coord_t'($urandom), coord_t'($urandom));

    // two frames, silent tracker
    do_start(8'd2);
    stream_frame(0, NPIX);
    frame_result("s3a", -1, '0, '0, '0, '0);
    stream_frame(0, NPIX);
    chk("s3_pushes", push_cnt - frame_base, NPIX);
    frame_result("s3b", -1, '0, '0, '0, '0);

    // tracker strobe coincides with timer expiry
    do_start(8'd1);
    stream_frame(2, NPIX);
    frame_result("s4", TO, coord_t'($urandom), coord_t'($urandom), coord_t'($urandom), coord_t'($urandom));

    // continuous run: mid-stream result, one frame, then abort (with start) after 13 pushes
    do_start(8'd0);
    rx = coord_t'($urandom); ry = coord_t'($urandom); rw = coord_t'($urandom); rh = coord_t'($urandom);
    t = cyc;
    bus.trk_valid = 1'b1;
    bus.trk_center_x = rx; bus.trk_center_y = ry; bus.trk_width = rw; bus.trk_height = rh;
    tick();
    bus.trk_valid = 1'b0;
    tick();
    chk("s5_mid_rv", rv_cyc, t + 1);
    chk("s5_mid_geom", {bus.res_center_x, bus.res_center_y, bus.res_width, bus.res_height},
        {rx, ry, rw, rh});
    chk("s5_mid_frame", {bus.res_frame, bus.res_timeout}, {fc, 1'b0});
    chk("s5_mid_busy", busy, 1'b1);
    stream_frame(2, NPIX);
    chk("s5_pushes", push_cnt - frame_base, NPIX);
    frame_result("s5a", $urandom_range(1, 12), coord_t'($urandom), coord_t'($urandom),
                 coord_t'($urandom), coord_t'($urandom));
    stream_frame(0, 13);
    pre   = push_cnt;
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("s5_abort_nopush", push_cnt, pre);
    chk("s5_abort_idle", {busy, done}, 2'b00);
    chk("s5_abort_fc_kept", frame_count, fc);
    do_start(8'd1);
    chk("s5_restart_fc", frame_count, 8'd0);
    stream_frame(2, NPIX);
    frame_result("s5b", $urandom_range(1, 15), coord_t'($urandom), coord_t'($urandom),
                 coord_t'($urandom), coord_t'($urandom));

    // asynchronous reset between edges in the middle of a frame
    do_start(8'd1);
    stream_frame(0, 10);
    #3 reset = 1'b0;
    #1;
    chk_zero("s6_async");
    @(negedge clock_50);
    @(negedge clock_50);
    reset = 1'b1;
    tot   = 0;
    do_start(8'd1);
    stream_frame(0, NPIX);
    chk("s6_pushes", push_cnt - frame_base, NPIX);
    frame_result("s6", 5, 12'd3, 12'd2, 12'd4, 12'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
